// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares one physical-memory port between the I-cache line-fill interface
//   and the D-cache line-fill/writeback interface. One requester is granted
//   at a time. Its request is registered and held on mem_* until mem_resp.
//   The response is routed back combinationally to the granted cache only.
//   Contention is resolved round-robin against the last grant.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_pmem_read/addr             I-cache fill request (read only)
//   i_pmem_rdata/resp            line + one-cycle completion to I-cache
//   d_pmem_read/write/addr/wdata D-cache fill / writeback request
//   d_pmem_rdata/resp            line + one-cycle completion to D-cache
//   mem_read/write/addr/wdata    registered request to memory, held until mem_resp
//   mem_rdata/resp               memory response
//   grant_d                      1 while the D-cache owns memory
module pmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_addr,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_addr,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              grant_d
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t state, state_nxt;
   logic   last_d;          // 1 = D-cache received the most recent grant
   logic   pick_i, pick_d;  // grant decision, only ever set in IDLE
   logic   d_req;

   assign d_req = d_pmem_read | d_pmem_write;

   // Next state and grant decision
   always_comb begin
      state_nxt = state;
      pick_i    = 1'b0;
      pick_d    = 1'b0;
      case (state)
         IDLE: begin
            if (i_pmem_read && d_req) begin
               // Contention: hand memory to whoever did not have it last
               pick_i = last_d;
               pick_d = ~last_d;
            end else begin
               pick_i = i_pmem_read;
               pick_d = d_req;
            end
            if (pick_d)      state_nxt = SERVE_D;
            else if (pick_i) state_nxt = SERVE_I;
         end
         SERVE_I: if (mem_resp) state_nxt = IDLE;
         SERVE_D: if (mem_resp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and latched memory request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         last_d    <= 1'b1;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (pick_d) begin
            last_d    <= 1'b1;
            mem_addr  <= d_pmem_addr;
            mem_wdata <= d_pmem_wdata;
            // Read and write together is illegal; the writeback wins so dirty data is never lost
            mem_write <= d_pmem_write;
            mem_read  <= d_pmem_read & ~d_pmem_write;
         end else if (pick_i) begin
            last_d    <= 1'b0;
            mem_addr  <= i_pmem_addr;
            mem_wdata <= '0;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
         end else if (state != IDLE && mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
      end
   end

   // Response routing: zero added latency, the idle cache sees all zeros.
   // A mem_resp arriving in IDLE matches neither state and is dropped.
   assign grant_d      = (state == SERVE_D);
   assign i_pmem_resp  = (state == SERVE_I) & mem_resp;
   assign d_pmem_resp  = (state == SERVE_D) & mem_resp;
   assign i_pmem_rdata = (state == SERVE_I) ? mem_rdata : '0;
   assign d_pmem_rdata = (state == SERVE_D) ? mem_rdata : '0;

   a_d_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(d_pmem_read && d_pmem_write))
      else $warning("pmem_arbiter: d_pmem_read and d_pmem_write both set, writeback issued");

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Scoreboard bench: every scenario pushes the expected memory request and the
//   expected cache response. A behavioural memory pops and checks requests. A
//   response monitor pops and checks what the caches receive.
module tb_pmem_arbiter;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              i_pmem_read;
   logic [ADDR_W-1:0] i_pmem_addr;
   logic [LINE_W-1:0] i_pmem_rdata;
   logic              i_pmem_resp;
   logic              d_pmem_read, d_pmem_write;
   logic [ADDR_W-1:0] d_pmem_addr;
   logic [LINE_W-1:0] d_pmem_wdata;
   logic [LINE_W-1:0] d_pmem_rdata;
   logic              d_pmem_resp;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic              grant_d;

   always #5 clk = ~clk;

   pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .grant_d(grant_d)
   );

   typedef struct {
      logic              d;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
   } req_t;
   typedef struct {
      logic              d;
      logic [LINE_W-1:0] rdata;
   } rsp_t;

   req_t exp_req[$];
   rsp_t exp_rsp[$];
   int   checks = 0;
   int   errors = 0;
   int   lat    = 5;     // memory cycles from first seen request to mem_resp
   bit   spur   = 1'b0;  // ask the memory for one unsolicited mem_resp

   localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [LINE_W-1:0] PAT_DB = {4{32'hDEADBEEF}};

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic expect_req(input logic d, input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd);
      req_t r;
      r.d = d; r.wr = wr; r.addr = a; r.wdata = wd; r.rdata = rd;
      exp_req.push_back(r);
   endtask

   task automatic expect_txn(input logic d, input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd);
      rsp_t s;
      expect_req(d, wr, a, wd, rd);
      s.d = d; s.rdata = rd;
      exp_rsp.push_back(s);
   endtask

   // Wait until every expected response has been seen
   task automatic drain(input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (exp_rsp.size() == 0) return;
      end
      chk("drain_timeout", LINE_W'(exp_rsp.size()), '0);
      exp_rsp.delete();
   endtask

   // Behavioural memory, driven 1 time unit after each rising edge
   initial begin : mem_model
      req_t cur;
      int   cnt;
      bit   busy, gap;
      mem_resp = 1'b0; mem_rdata = '0;
      busy = 1'b0; gap = 1'b0; cnt = 0;
      cur.d = 1'b0; cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0; cur.rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_resp = 1'b0; mem_rdata = '0;
         if (!reset_n) begin
            busy = 1'b0; gap = 1'b0;
         end else if (spur) begin
            mem_resp = 1'b1; mem_rdata = {16{8'h3C}}; spur = 1'b0;
         end else if (gap) begin
            // Arbiter must idle for one cycle after every response
            chk("idle_gap", LINE_W'(mem_read | mem_write), '0);
            gap = 1'b0;
         end else if (mem_read | mem_write) begin
            if (!busy) begin
               busy = 1'b1; cnt = 0;
               if (exp_req.size() == 0) begin
                  chk("unexpected_req", LINE_W'(mem_read | mem_write), '0);
                  cur.d = grant_d; cur.wr = mem_write; cur.addr = mem_addr;
                  cur.wdata = mem_wdata; cur.rdata = '0;
               end else begin
                  cur = exp_req.pop_front();
                  chk("grant_d", LINE_W'(grant_d), LINE_W'(cur.d));
               end
            end
            chk("mem_addr", LINE_W'(mem_addr), LINE_W'(cur.addr));
            chk("mem_write", LINE_W'(mem_write), LINE_W'(cur.wr));
            chk("mem_read", LINE_W'(mem_read), LINE_W'(!cur.wr));
            if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
            cnt++;
            if (cnt >= lat) begin
               mem_resp = 1'b1; mem_rdata = cur.rdata; busy = 1'b0; gap = 1'b1;
            end
         end else begin
            busy = 1'b0;
         end
      end
   end

   // Response monitor
   initial begin : rsp_mon
      rsp_t s;
      forever begin
         @(negedge clk);
         if (i_pmem_resp || d_pmem_resp) begin
            if (exp_rsp.size() == 0) begin
               chk("unexpected_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
            end else begin
               s = exp_rsp.pop_front();
               chk("resp_d", LINE_W'(d_pmem_resp), LINE_W'(s.d));
               chk("resp_i", LINE_W'(i_pmem_resp), LINE_W'(!s.d));
               chk("resp_rdata", s.d ? d_pmem_rdata : i_pmem_rdata, s.rdata);
               chk("other_rdata", s.d ? i_pmem_rdata : d_pmem_rdata, '0);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin : stim
      reset_n = 1'b0;
      i_pmem_read = 1'b0; i_pmem_addr = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_mem_read", LINE_W'(mem_read), '0);
      chk("rst_mem_write", LINE_W'(mem_write), '0);
      chk("rst_mem_addr", LINE_W'(mem_addr), '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_grant_d", LINE_W'(grant_d), '0);
      @(posedge clk); #1 reset_n = 1'b1;

      // I-only read: one decision cycle, then the request appears on memory
      lat = 5;
      expect_txn(1'b0, 1'b0, 16'h1230, '0, PAT_A5);
      i_pmem_read = 1'b1; i_pmem_addr = 16'h1230;
      @(negedge clk);
      chk("decision_cycle", LINE_W'(mem_read), '0);
      @(negedge clk);
      chk("t1_mem_read", LINE_W'(mem_read), 1);
      chk("t1_mem_addr", LINE_W'(mem_addr), LINE_W'(16'h1230));
      drain(30);
      @(posedge clk); #1 i_pmem_read = 1'b0;

      // D writeback
      expect_txn(1'b1, 1'b1, 16'h4440, PAT_DB, {16{8'h5A}});
      d_pmem_write = 1'b1; d_pmem_addr = 16'h4440; d_pmem_wdata = PAT_DB;
      drain(30);
      @(posedge clk); #1 d_pmem_write = 1'b0; d_pmem_wdata = '0;

      // Both held continuously: last grant was D, so I,D,I,D
      lat = 3;
      expect_txn(1'b0, 1'b0, 16'h1000, '0, {8{16'h1111}});
      expect_txn(1'b1, 1'b0, 16'h2000, '0, {8{16'h2222}});
      expect_txn(1'b0, 1'b0, 16'h1000, '0, {8{16'h3333}});
      expect_txn(1'b1, 1'b0, 16'h2000, '0, {8{16'h4444}});
      i_pmem_read = 1'b1; i_pmem_addr = 16'h1000;
      d_pmem_read = 1'b1; d_pmem_addr = 16'h2000;
      drain(80);
      @(posedge clk); #1 i_pmem_read = 1'b0; d_pmem_read = 1'b0;

      // Address changes mid-service are ignored
      lat = 6;
      expect_txn(1'b1, 1'b0, 16'h4440, '0, {8{16'h6789}});
      d_pmem_read = 1'b1; d_pmem_addr = 16'h4440;
      repeat (3) @(posedge clk);
      #1 d_pmem_addr = 16'h5550;
      drain(30);
      @(posedge clk); #1 d_pmem_read = 1'b0;

      // Spurious mem_resp while idle
      repeat (2) @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      chk("spur_i_resp", LINE_W'(i_pmem_resp), '0);
      chk("spur_d_resp", LINE_W'(d_pmem_resp), '0);
      chk("spur_grant_d", LINE_W'(grant_d), '0);

      // Illegal read+write: writeback issued
      @(posedge clk); #1;
      lat = 4;
      expect_txn(1'b1, 1'b1, 16'h6660, {4{32'h0BAD_F00D}}, {8{16'h7777}});
      d_pmem_read = 1'b1; d_pmem_write = 1'b1;
      d_pmem_addr = 16'h6660; d_pmem_wdata = {4{32'h0BAD_F00D}};
      drain(30);
      @(posedge clk); #1 d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;

      // Reset in the middle of an I-cache fill: abandoned, no stale response
      lat = 10;
      expect_req(1'b0, 1'b0, 16'h7770, '0, {8{16'h8888}});
      i_pmem_read = 1'b1; i_pmem_addr = 16'h7770;
      repeat (4) @(negedge clk);
      chk("pre_rst_mem_read", LINE_W'(mem_read), 1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_mem_read", LINE_W'(mem_read), '0);
      chk("async_rst_mem_addr", LINE_W'(mem_addr), '0);
      chk("async_rst_i_rdata", i_pmem_rdata, '0);
      chk("async_rst_grant_d", LINE_W'(grant_d), '0);
      i_pmem_read = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("post_rst_mem_read", LINE_W'(mem_read), '0);

      // last grant back to D after reset: contention grants I first
      lat = 2;
      expect_txn(1'b0, 1'b0, 16'h0AA0, '0, {8{16'h9999}});
      expect_txn(1'b1, 1'b0, 16'h0BB0, '0, {8{16'hAAAA}});
      @(posedge clk); #1;
      i_pmem_read = 1'b1; i_pmem_addr = 16'h0AA0;
      d_pmem_read = 1'b1; d_pmem_addr = 16'h0BB0;
      drain(40);
      @(posedge clk); #1 i_pmem_read = 1'b0; d_pmem_read = 1'b0;
      repeat (4) @(negedge clk);

      chk("req_queue_empty", LINE_W'(exp_req.size()), '0);
      chk("rsp_queue_empty", LINE_W'(exp_rsp.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
